// File: rtl/imm_decode_stage.sv
// RV32I decode-stage front end: opcode -> immediate-type classification feeding a
// 2-entry skid buffer toward execute. Define IMM_DECODE_CSR_EN to decode SYSTEM/CSR forms.
module imm_decode_stage #(
    parameter logic [2:0] I_TYPE       = 3'b000,
    parameter logic [2:0] B_TYPE       = 3'b001,
    parameter logic [2:0] S_TYPE       = 3'b010,
    parameter logic [2:0] U_TYPE       = 3'b011,
    parameter logic [2:0] J_TYPE       = 3'b100,
    parameter logic [2:0] SHAMT_TYPE   = 3'b101,
    parameter logic [2:0] CSR_TYPE     = 3'b110,
    parameter logic [2:0] DEFAULT_TYPE = 3'b111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_ir,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ir,
    output logic [31:0] out_pc,
    output logic [2:0]  out_imm_type,
    output logic        out_illegal
);

    // Returns {illegal, imm_type} for one opcode/funct3 pair.
    function automatic logic [3:0] decode(input logic [6:0] opc, input logic [2:0] f3);
        logic [2:0] t;
        logic       ill;
        t   = DEFAULT_TYPE;
        ill = 1'b0;
        case (opc)
            7'b0110111, 7'b0010111: t = U_TYPE;
            7'b1101111: t = J_TYPE;
            7'b1100111: begin
                t   = I_TYPE;
                ill = (f3 != 3'b000);
            end
            7'b1100011: begin
                t   = B_TYPE;
                ill = (f3 == 3'b010) || (f3 == 3'b011);
            end
            7'b0000011: t = I_TYPE;
            7'b0100011: t = S_TYPE;
            7'b0010011: t = ((f3 == 3'b001) || (f3 == 3'b101)) ? SHAMT_TYPE : I_TYPE;
            7'b0110011, 7'b0001111: t = DEFAULT_TYPE;
            7'b1110011: begin
`ifdef IMM_DECODE_CSR_EN
                case (f3)
                    3'b101, 3'b110, 3'b111: t = CSR_TYPE;
                    3'b100:                 ill = 1'b1;
                    default:                t = DEFAULT_TYPE;
                endcase
`else
                ill = (f3 != 3'b000);
`endif
            end
            default: ill = 1'b1;
        endcase
        return {ill, t};
    endfunction

    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [3:0]  in_dec;
    logic        accept;
    logic        pop;

    logic        m_valid_q, m_valid_d;
    logic        k_valid_q, k_valid_d;
    logic        in_ready_q, in_ready_d;
    logic [31:0] m_ir_q, m_ir_d, m_pc_q, m_pc_d;
    logic [2:0]  m_type_q, m_type_d;
    logic        m_ill_q, m_ill_d;
    logic [31:0] k_ir_q, k_ir_d, k_pc_q, k_pc_d;
    logic [2:0]  k_type_q, k_type_d;
    logic        k_ill_q, k_ill_d;

    assign in_opcode = in_ir[6:0];
    assign in_funct3 = in_ir[14:12];
    assign in_dec    = decode(in_opcode, in_funct3);
    assign accept    = in_valid & in_ready_q;
    assign pop       = m_valid_q & out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        k_valid_d = k_valid_q;
        m_ir_d    = m_ir_q;
        m_pc_d    = m_pc_q;
        m_type_d  = m_type_q;
        m_ill_d   = m_ill_q;
        k_ir_d    = k_ir_q;
        k_pc_d    = k_pc_q;
        k_type_d  = k_type_q;
        k_ill_d   = k_ill_q;
        if (flush) begin
            m_valid_d = 1'b0;
            k_valid_d = 1'b0;
        end else if (pop && k_valid_q) begin
            // in_ready is low whenever K is valid, so no accept can collide here
            m_valid_d = 1'b1;
            k_valid_d = 1'b0;
            m_ir_d    = k_ir_q;
            m_pc_d    = k_pc_q;
            m_type_d  = k_type_q;
            m_ill_d   = k_ill_q;
        end else if (accept && (pop || !m_valid_q)) begin
            m_valid_d = 1'b1;
            m_ir_d    = in_ir;
            m_pc_d    = in_pc;
            m_type_d  = in_dec[2:0];
            m_ill_d   = in_dec[3];
        end else if (accept) begin
            k_valid_d = 1'b1;
            k_ir_d    = in_ir;
            k_pc_d    = in_pc;
            k_type_d  = in_dec[2:0];
            k_ill_d   = in_dec[3];
        end else if (pop) begin
            m_valid_d = 1'b0;
        end
        in_ready_d = !k_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q  <= 1'b0;
            k_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
            m_ir_q     <= 32'd0;
            m_pc_q     <= 32'd0;
            m_type_q   <= DEFAULT_TYPE;
            m_ill_q    <= 1'b0;
        end else begin
            m_valid_q  <= m_valid_d;
            k_valid_q  <= k_valid_d;
            in_ready_q <= in_ready_d;
            m_ir_q     <= m_ir_d;
            m_pc_q     <= m_pc_d;
            m_type_q   <= m_type_d;
            m_ill_q    <= m_ill_d;
        end
    end

    // Skid payload is only observed once K.valid is set, so it needs no reset.
    always_ff @(posedge clk) begin
        k_ir_q   <= k_ir_d;
        k_pc_q   <= k_pc_d;
        k_type_q <= k_type_d;
        k_ill_q  <= k_ill_d;
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = m_valid_q;
    assign out_ir       = m_ir_q;
    assign out_pc       = m_pc_q;
    assign out_imm_type = m_type_q;
    assign out_illegal  = m_ill_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed-vector bench for imm_decode_stage: decode map, skid buffering, flush and async reset.
module tb_imm_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ir;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic [31:0] out_pc;
    logic [2:0]  out_imm_type;
    logic        out_illegal;

    int n_cmp = 0;
    int n_err = 0;

    imm_decode_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ir        (in_ir),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ir       (out_ir),
        .out_pc       (out_pc),
        .out_imm_type (out_imm_type),
        .out_illegal  (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_ir"}, out_ir, 32'd0);
        chk({tag, "_out_pc"}, out_pc, 32'd0);
        chk({tag, "_imm_type"}, 32'(out_imm_type), 32'd7);
        chk({tag, "_illegal"}, 32'(out_illegal), 32'd0);
    endtask

    logic [31:0] b2b_ir   [5] = '{32'h00209093, 32'hFE000EE3, 32'h00112223, 32'h0000006F, 32'h123450B7};
    logic [2:0]  b2b_type [5] = '{3'b101, 3'b001, 3'b010, 3'b100, 3'b011};

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ir = 32'd0; in_pc = 32'd0;
        step(); step();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        step();

        // single addi
        in_valid = 1'b1; in_ir = 32'h00500093; in_pc = 32'h00000100;
        chk("addi_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_type", 32'(out_imm_type), 32'd0);
        chk("addi_illegal", 32'(out_illegal), 32'd0);
        chk("addi_pc", out_pc, 32'h00000100);
        chk("addi_ir", out_ir, 32'h00500093);
        step();
        chk("addi_drain", 32'(out_valid), 32'd0);

        // back-to-back stream, no bubbles
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_ir = b2b_ir[i]; in_pc = 32'h1000 + 32'(i * 4);
            chk($sformatf("b2b%0d_in_ready", i), 32'(in_ready), 32'd1);
            step();
            chk($sformatf("b2b%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("b2b%0d_type", i), 32'(out_imm_type), 32'(b2b_type[i]));
            chk($sformatf("b2b%0d_pc", i), out_pc, 32'h1000 + 32'(i * 4));
            chk($sformatf("b2b%0d_illegal", i), 32'(out_illegal), 32'd0);
        end
        in_valid = 1'b0;
        step();
        chk("b2b_drain", 32'(out_valid), 32'd0);

        // stall: A to M, B to K, C refused
        out_ready = 1'b0;
        in_valid = 1'b1; in_ir = 32'h00500093; in_pc = 32'h200;
        step();
        chk("stall_a_valid", 32'(out_valid), 32'd1);
        chk("stall_a_ready", 32'(in_ready), 32'd1);
        in_ir = 32'h00112223; in_pc = 32'h204;
        step();
        chk("stall_full_ready", 32'(in_ready), 32'd0);
        chk("stall_m_pc", out_pc, 32'h200);
        in_ir = 32'h0000006F; in_pc = 32'h208;
        step();
        chk("stall_hold_pc", out_pc, 32'h200);
        chk("stall_hold_type", 32'(out_imm_type), 32'd0);
        chk("stall_hold_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        chk("drain_b_pc", out_pc, 32'h204);
        chk("drain_b_type", 32'(out_imm_type), 32'd2);
        chk("drain_b_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("drain_c_pc", out_pc, 32'h208);
        chk("drain_c_type", 32'(out_imm_type), 32'd4);
        chk("drain_c_valid", 32'(out_valid), 32'd1);
        step();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // flush with both entries full
        out_ready = 1'b0;
        in_valid = 1'b1; in_ir = 32'h00500093; in_pc = 32'h300;
        step();
        in_ir = 32'h00112223; in_pc = 32'h304;
        step();
        chk("pre_flush_ready", 32'(in_ready), 32'd0);
        flush = 1'b1; in_ir = 32'h0000006F; in_pc = 32'h308;
        step();
        chk("flush_full_valid", 32'(out_valid), 32'd0);
        chk("flush_full_ready", 32'(in_ready), 32'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("flush_full_after", 32'(out_valid), 32'd0);

        // flush discards a same-cycle accept
        out_ready = 1'b0;
        in_valid = 1'b1; in_ir = 32'h00500093; in_pc = 32'h400;
        step();
        flush = 1'b1; in_ir = 32'h123450B7; in_pc = 32'h404;
        step();
        chk("flush_acc_valid", 32'(out_valid), 32'd0);
        chk("flush_acc_ready", 32'(in_ready), 32'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("flush_acc_after", 32'(out_valid), 32'd0);

        // SYSTEM opcode handling
        in_valid = 1'b1; in_ir = 32'h34029073; in_pc = 32'h500;
        step();
`ifdef IMM_DECODE_CSR_EN
        chk("csrrw_type", 32'(out_imm_type), 32'd7);
        chk("csrrw_illegal", 32'(out_illegal), 32'd0);
`else
        chk("csrrw_type", 32'(out_imm_type), 32'd7);
        chk("csrrw_illegal", 32'(out_illegal), 32'd1);
`endif
        in_ir = 32'h3402D073; in_pc = 32'h504;
        step();
`ifdef IMM_DECODE_CSR_EN
        chk("csrrwi_type", 32'(out_imm_type), 32'd6);
        chk("csrrwi_illegal", 32'(out_illegal), 32'd0);
`else
        chk("csrrwi_type", 32'(out_imm_type), 32'd7);
        chk("csrrwi_illegal", 32'(out_illegal), 32'd1);
`endif

        // unknown opcode, then fill both entries and reset asynchronously
        in_ir = 32'h0000007F; in_pc = 32'h508;
        step();
        chk("bad_op_type", 32'(out_imm_type), 32'd7);
        chk("bad_op_illegal", 32'(out_illegal), 32'd1);
        chk("bad_op_pc", out_pc, 32'h508);
        out_ready = 1'b0;
        in_ir = 32'h00500093; in_pc = 32'h50C;
        step();
        in_ir = 32'h00209093; in_pc = 32'h510;
        step();
        chk("pre_arst_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        #10;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_arst_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
